// File: rtl/turfio_pkg.sv
// Constants and types shared by the TURFIO command paths (COUT serializer, CIN parallelizer).
package turfio_pkg;

  localparam int unsigned NIBBLES_PER_WORD = 8;
  localparam int unsigned NIBBLE_CNT_W     = $clog2(NIBBLES_PER_WORD);

  localparam logic [31:0] TRAIN_PATTERN_DEFAULT = 32'hA55A6996;
  localparam logic [31:0] IDLE_WORD_DEFAULT     = 32'h00000000;

  typedef logic [3:0]  nibble_t;
  typedef logic [31:0] word_t;

  // Nibble that leaves first for a given bit order.
  function automatic nibble_t first_nibble(input word_t w, input logic msb_first);
    return msb_first ? w[31:28] : w[3:0];
  endfunction

endpackage

// File: rtl/turfio_cout_serializer_if.sv
// Handshake and output bundle of the COUT serializer.
interface turfio_cout_serializer_if;
  import turfio_pkg::*;

  logic    ce_i;
  logic    align_i;
  logic    train_en_i;
  word_t   response_i;
  logic    response_valid_i;
  logic    response_ready_o;
  nibble_t cout_o;
  logic    cout_valid_o;
  logic    word_start_o;
  logic    overflow_o;
  logic    abort_o;

  // Producer / controller side.
  modport master (
    output ce_i, align_i, train_en_i, response_i, response_valid_i,
    input  response_ready_o, cout_o, cout_valid_o, word_start_o, overflow_o, abort_o
  );

  // Serializer side.
  modport slave (
    input  ce_i, align_i, train_en_i, response_i, response_valid_i,
    output response_ready_o, cout_o, cout_valid_o, word_start_o, overflow_o, abort_o
  );
endinterface

// File: rtl/turfio_word_skid.sv
// One-entry pending buffer for response words, with sticky overflow detection.
module turfio_word_skid
  import turfio_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  word_t in_data,
  input  logic  in_valid,
  output logic  in_ready,
  input  logic  pop,
  output word_t pend_data,
  output logic  pend_full,
  output logic  overflow
);

  word_t data_q, data_d;
  logic  full_q, full_d;
  logic  ovf_q, ovf_d;
  logic  push;

  // A pop in the same cycle frees the slot, so a new word may land immediately.
  assign in_ready = ~full_q | pop;
  assign push     = in_valid & in_ready;

  // Next-state: push overrides pop so a same-cycle refill keeps the buffer full.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    ovf_d  = ovf_q;
    if (push) begin
      data_d = in_data;
      full_d = 1'b1;
    end else if (pop) begin
      full_d = 1'b0;
    end
    if (in_valid && !in_ready) begin
      ovf_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pend_data = data_q;
  assign pend_full = full_q;
  assign overflow  = ovf_q;

endmodule

// File: rtl/turfio_cout_serializer.sv
// Serializes 32-bit response words into nibbles, one per ce strobe, inserting
// idle or training words so the far end can lock and bitslip COUT.
module turfio_cout_serializer
  import turfio_pkg::*;
#(
  parameter logic [31:0] TRAIN_PATTERN = TRAIN_PATTERN_DEFAULT,
  parameter logic [31:0] IDLE_WORD     = IDLE_WORD_DEFAULT,
  parameter bit          MSB_FIRST     = 1'b1
) (
  input logic                     aclk_i,
  input logic                     aclk_rst_i,
  turfio_cout_serializer_if.slave bus
);

  logic [NIBBLE_CNT_W-1:0] nibble_cnt_q;
  word_t                   shreg_q;
  nibble_t                 cout_q;
  logic                    cout_valid_q;
  logic                    word_start_q;
  logic                    abort_q;

  logic                    boundary;
  logic                    load_now;
  logic                    pend_full;
  logic                    overflow;
  word_t                   pend_data;
  word_t                   next_word;

  assign boundary = bus.ce_i & ((nibble_cnt_q == '0) | bus.align_i);
  // Training words never come from the buffer, so the buffer is only drained when not training.
  assign load_now = boundary & ~bus.train_en_i;

  turfio_word_skid u_skid (
    .clk       (aclk_i),
    .rst       (aclk_rst_i),
    .in_data   (bus.response_i),
    .in_valid  (bus.response_valid_i),
    .in_ready  (bus.response_ready_o),
    .pop       (load_now),
    .pend_data (pend_data),
    .pend_full (pend_full),
    .overflow  (overflow)
  );

  // Word chosen at a boundary: training beats pending data beats idle.
  always_comb begin
    next_word = IDLE_WORD;
    if (bus.train_en_i) begin
      next_word = TRAIN_PATTERN;
    end else if (pend_full) begin
      next_word = pend_data;
    end
  end

  // Nibble shifter, counter and registered output strobes.
  always_ff @(posedge aclk_i) begin
    if (aclk_rst_i) begin
      nibble_cnt_q <= '0;
      shreg_q      <= '0;
      cout_q       <= '0;
      cout_valid_q <= 1'b0;
      word_start_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      cout_valid_q <= bus.ce_i;
      word_start_q <= boundary;
      if (boundary) begin
        cout_q       <= first_nibble(next_word, MSB_FIRST);
        shreg_q      <= MSB_FIRST ? (next_word << 4) : (next_word >> 4);
        nibble_cnt_q <= NIBBLE_CNT_W'(1);
        // An align in mid-word cuts the current word short.
        if (bus.align_i && (nibble_cnt_q != '0)) begin
          abort_q <= 1'b1;
        end
      end else if (bus.ce_i) begin
        cout_q       <= MSB_FIRST ? shreg_q[31:28] : shreg_q[3:0];
        shreg_q      <= MSB_FIRST ? (shreg_q << 4) : (shreg_q >> 4);
        nibble_cnt_q <= nibble_cnt_q + NIBBLE_CNT_W'(1);
      end
    end
  end

  assign bus.cout_o       = cout_q;
  assign bus.cout_valid_o = cout_valid_q;
  assign bus.word_start_o = word_start_q;
  assign bus.overflow_o   = overflow;
  assign bus.abort_o      = abort_q;

endmodule

// File: tb/tb_turfio_cout_serializer.sv
// Directed plus randomized bench for the COUT serializer, checked against a word-level model.
module tb_turfio_cout_serializer;
  import turfio_pkg::*;

  logic clk;
  logic rst;

  turfio_cout_serializer_if bus ();

  turfio_cout_serializer dut (
    .aclk_i     (clk),
    .aclk_rst_i (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ws_count = 0;

  // Reference model: the word in flight, how many nibbles of it have gone, and what waits.
  logic [31:0] m_cur;
  int          m_sent;
  logic [31:0] m_pend[$];
  logic [3:0]  m_nib;
  logic        m_valid;
  logic        m_ws;
  logic        m_ovf;
  logic        m_abt;
  logic [3:0]  got[$];

  function automatic logic [3:0] nib_of(input logic [31:0] w, input int k);
    logic [31:0] t;
    t = w >> (28 - 4 * k);
    return t[3:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cur   = 32'h0;
    m_sent  = 0;
    m_pend.delete();
    m_nib   = 4'h0;
    m_valid = 1'b0;
    m_ws    = 1'b0;
    m_ovf   = 1'b0;
    m_abt   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.ce_i = 1'b0;
    bus.align_i = 1'b0;
    bus.train_en_i = 1'b0;
    bus.response_valid_i = 1'b0;
    bus.response_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_cout", {28'h0, bus.cout_o}, 32'h0);
    chk("rst_valid", {31'h0, bus.cout_valid_o}, 32'h0);
    chk("rst_ws", {31'h0, bus.word_start_o}, 32'h0);
    chk("rst_ovf", {31'h0, bus.overflow_o}, 32'h0);
    chk("rst_abort", {31'h0, bus.abort_o}, 32'h0);
    chk("rst_ready", {31'h0, bus.response_ready_o}, 32'h1);
  endtask

  // One clock of stimulus; the model advances alongside and every output is compared.
  task automatic step(input logic ce, input logic al, input logic tr, input logic vl,
                      input logic [31:0] d);
    logic at_boundary;
    logic exp_ready;
    @(negedge clk);
    rst = 1'b0;
    bus.ce_i = ce;
    bus.align_i = al;
    bus.train_en_i = tr;
    bus.response_valid_i = vl;
    bus.response_i = d;
    #1;
    at_boundary = ce && (m_sent == 8 || m_sent == 0 || al);
    exp_ready = (m_pend.size() == 0) || (at_boundary && !tr);
    chk("ready", {31'h0, bus.response_ready_o}, {31'h0, exp_ready});
    m_ws = 1'b0;
    m_valid = ce;
    if (at_boundary) begin
      if (al && m_sent != 8 && m_sent != 0) m_abt = 1'b1;
      if (tr) m_cur = TRAIN_PATTERN_DEFAULT;
      else if (m_pend.size() != 0) m_cur = m_pend.pop_front();
      else m_cur = IDLE_WORD_DEFAULT;
      m_nib = nib_of(m_cur, 0);
      m_sent = 1;
      m_ws = 1'b1;
    end else if (ce) begin
      m_nib = nib_of(m_cur, m_sent);
      m_sent = m_sent + 1;
    end
    if (vl) begin
      if (exp_ready) m_pend.push_back(d);
      else m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("cout_valid", {31'h0, bus.cout_valid_o}, {31'h0, m_valid});
    chk("word_start", {31'h0, bus.word_start_o}, {31'h0, m_ws});
    chk("cout", {28'h0, bus.cout_o}, {28'h0, m_nib});
    chk("overflow", {31'h0, bus.overflow_o}, {31'h0, m_ovf});
    chk("abort", {31'h0, bus.abort_o}, {31'h0, m_abt});
    if (bus.cout_valid_o) got.push_back(bus.cout_o);
    if (bus.word_start_o) ws_count++;
  endtask

  // Compare eight captured nibbles starting at idx against a literal word, MSB first.
  task automatic chk_word(input string tag, input int idx, input logic [31:0] w);
    logic [31:0] obs;
    if (idx + 8 > got.size()) begin
      chk({tag, "_len"}, got.size(), idx + 8);
    end else begin
      obs = 32'h0;
      for (int k = 0; k < 8; k++) obs = {obs[27:0], got[idx + k]};
      chk(tag, obs, w);
    end
  endtask

  int idx;
  logic tr_r;

  initial begin
    rst = 1'b1;
    bus.ce_i = 1'b0;
    bus.align_i = 1'b0;
    bus.train_en_i = 1'b0;
    bus.response_valid_i = 1'b0;
    bus.response_i = 32'h0;
    model_reset();

    do_reset();

    // Idle stream with ce every third cycle.
    got.delete();
    ws_count = 0;
    for (int i = 0; i < 48; i++) step(i % 3 == 0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_word("idle0", 0, 32'h0);
    chk_word("idle1", 8, 32'h0);
    chk("idle_ws_count", ws_count, 2);

    // Single response.
    got.delete();
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_word("single", 0, 32'h12345678);
    chk_word("single_idle", 8, 32'h0);

    // Training raised and dropped mid-word.
    got.delete();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_word("train_pre", 0, 32'h0);
    chk_word("train0", 8, 32'hA55A6996);
    chk_word("train1", 16, 32'hA55A6996);
    chk_word("train_post", 24, 32'h0);

    // Back-to-back words, then one presented while full.
    for (int i = 0; i < 8 && m_sent != 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    got.delete();
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
    chk("ready_low", {31'h0, bus.response_ready_o}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h11111111);
    for (int i = 0; i < 22; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_word("b2b0", 0, 32'hDEADBEEF);
    chk_word("b2b1", 8, 32'hCAFEF00D);
    chk_word("b2b_idle", 16, 32'h0);
    chk("ovf_sticky", {31'h0, bus.overflow_o}, 32'h1);

    // Align in mid-word: pending word starts afresh.
    for (int i = 0; i < 8 && m_sent != 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h13579BDF);
    for (int i = 0; i < 8 && m_sent != 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    idx = got.size();
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("align_abort", {31'h0, bus.abort_o}, 32'h1);
    chk("align_ws", {31'h0, bus.word_start_o}, 32'h1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_word("align_word", idx, 32'h13579BDF);

    // Randomized traffic within the one-word-per-eight-nibbles rate.
    tr_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(59) == 0) tr_r = ~tr_r;
      step(1'($urandom_range(1)), 1'($urandom_range(39) == 0), tr_r,
           1'((m_pend.size() == 0) && ($urandom_range(3) == 0)), $urandom);
    end

    // Reset clears the sticky flags.
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case anything above ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/turfio_cout_serializer.md
Name: turfio_cout_serializer

Overview:
- Transmit-side counterpart of the CIN command path. Takes 32-bit response words in the aclk domain and serializes them into 4-bit nibbles, one nibble per nibble-slot strobe (ce), for the COUT output serializer.
- Inserts an idle word when nothing is pending and a training word while training is enabled. The TURFIO end can therefore lock and bitslip COUT the same way the SURF locks CIN.

Parameters:
- TRAIN_PATTERN, 32'hA55A6996, word sent repeatedly while train_en_i=1.
- IDLE_WORD, 32'h00000000, word sent at a boundary when no response is pending.
- MSB_FIRST, 1'b1, 1 = nibble [31:28] goes out first; 0 = nibble [3:0] goes out first.

Ports:
- aclk_i, in, 1, sole clock.
- aclk_rst_i, in, 1, synchronous active-high reset.
- ce_i, in, 1, nibble-slot strobe; one nibble is consumed per asserted cycle.
- align_i, in, 1, forces a word boundary; sampled only when ce_i=1.
- train_en_i, in, 1, send TRAIN_PATTERN instead of responses or idle.
- response_i, in, 32, response word.
- response_valid_i, in, 1, response_i is valid.
- response_ready_o, out, 1, block can accept a word this cycle.
- cout_o, out, 4, nibble to the output serializer.
- cout_valid_o, out, 1, one-cycle pulse; cout_o was updated this cycle.
- word_start_o, out, 1, pulses with cout_valid_o on the first nibble of a word.
- overflow_o, out, 1, sticky: a valid word was presented while response_ready_o=0.
- abort_o, out, 1, sticky: align_i truncated a word that was being sent.

Behaviour:
- Reset values: cout_o=0, cout_valid_o=0, word_start_o=0, overflow_o=0, abort_o=0, nibble_cnt=0, pending buffer empty, response_ready_o=1. Reset wins over every other input in the same cycle.
- State:
  - 1-entry pending buffer (pend_data, pend_full).
  - 32-bit shift register.
  - 3-bit nibble_cnt, counting 0..7.
- Handshake:
  - response_ready_o = ~pend_full | load_now.
  - load_now = ce_i & (nibble_cnt==0 | align_i) & ~train_en_i.
  - A transfer occurs when valid & ready. The word is written to pend_data and pend_full=1.
  - When load_now consumes the buffer and a new transfer happens in the same cycle, the new word goes into the buffer and pend_full stays 1.
- Word boundary: a ce_i cycle with nibble_cnt==0, or with align_i=1.
  - Next word is selected in priority order: train_en_i → TRAIN_PATTERN; pend_full → pend_data (buffer freed); otherwise IDLE_WORD.
  - The first nibble of the selected word is registered to cout_o. The remaining 28 bits go to the shift register. nibble_cnt becomes 1.
  - word_start_o=1 and cout_valid_o=1 in the cycle after the ce_i cycle (output is registered, latency 1).
- Non-boundary ce_i: the next nibble is shifted out to cout_o, and nibble_cnt increments, wrapping 7→0. cout_valid_o pulses.
- No ce_i: all state and outputs hold; cout_valid_o=0, word_start_o=0.
- align_i with ce_i while nibble_cnt≠0:
  - Current word is truncated and abort_o is set.
  - A new word is loaded as at a normal boundary.
  - align_i with nibble_cnt==0 is an ordinary boundary and sets no flag.
- train_en_i:
  - Takes effect only at the next boundary; a word already in progress completes.
  - Deasserting it also takes effect at a boundary.
  - The pending buffer is held, not dropped, during training. response_ready_o=~pend_full.
- overflow_o: set when response_valid_i=1 and response_ready_o=0. The presented word is discarded, not written. Cleared only by reset.
- Throughput: one word per 8 ce_i. The bench must not exceed this sustained rate.
- Back-to-back responses produce contiguous words with no idle word between them.

Decomposition:
- turfio_pkg holds: localparam NIBBLES_PER_WORD=8, default TRAIN_PATTERN, default IDLE_WORD, and typedef nibble_t (logic [3:0]). The CIN parallelizer uses the same constants.
- One optional sub-module: turfio_word_skid, the 1-entry pending buffer with ready/valid logic. Everything else stays flat.

Test Plan:
- Reset, then ce_i every 3rd cycle, no valid input → cout_o stream is all zeros; word_start_o every 8th cout_valid_o; overflow_o=0, abort_o=0.
- Single response 32'h12345678, MSB_FIRST=1 → after the current word ends, nibbles 1,2,3,4,5,6,7,8 appear on consecutive cout_valid_o pulses, then idle 0s.
- train_en_i=1 asserted mid-word → current word finishes, then A,5,5,A,6,9,9,6 repeats; drop train_en_i mid-word → pattern completes, then responses or idle resume.
- Two words 32'hDEADBEEF and 32'hCAFEF00D presented back-to-back with ce_i every cycle → response_ready_o drops after the second word; 16 contiguous nibbles D,E,A,D,B,E,E,F,C,A,F,E,F,0,0,D.
- Third word presented while response_ready_o=0 → overflow_o=1 and stays set; the third word never appears on cout_o.
- align_i at nibble_cnt=5 → abort_o=1; word_start_o pulses on the next cout_valid_o; the pending word starts at its first nibble.
